sym_src_upsampler: RTL and testbench

SYM_SRC_UPSAMPLER -- requirements
Module: sym_src_upsampler

---
 rtl/sym_src_upsampler.sv | 85 ++++++++
 tb/tb_sym_src_upsampler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sym_src_upsampler.sv
// 4-ASK symbol source (PRBS / constant / zero / alternating) upsampled by 4.
// Optional macro ZERO_STUFF_EN: zero-insertion instead of sample-and-hold.
module sym_src_upsampler #(
  parameter logic        [14:0] SEED   = 15'h0001,
  parameter logic signed [17:0] AMP_HI = 18'sd98304,
  parameter logic signed [17:0] AMP_LO = 18'sd32768
) (
  input  logic               clk,
  input  logic               reset,
  input  logic        [1:0]  sw,
  output logic               sam_clk_en,
  output logic               sym_clk_en,
  output logic signed [17:0] x_out,
  output logic        [1:0]  sam_cnt
);

  typedef enum logic [1:0] {
    SRC_PRBS  = 2'b00,
    SRC_CONST = 2'b01,
    SRC_ZERO  = 2'b10,
    SRC_ALT   = 2'b11
  } src_e;

  src_e               src;
  logic        [1:0]  clk_cnt;
  logic        [14:0] lfsr;
  logic        [14:0] lfsr_one;
  logic        [14:0] lfsr_two;
  logic               toggle;
  logic signed [17:0] sym_val;

  assign src        = src_e'(sw);
  assign sam_clk_en = (clk_cnt == 2'd3);
  assign sym_clk_en = (clk_cnt == 2'd3) && (sam_cnt == 2'd3);

  // Two shifts of x^15+x^14+1 per symbol: one 2-bit symbol consumed each time.
  assign lfsr_one = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
  assign lfsr_two = {lfsr_one[13:0], lfsr_one[14] ^ lfsr_one[13]};

  always_comb begin
    sym_val = '0;
    unique case (src)
      SRC_PRBS: begin
        unique case (lfsr[1:0])
          2'b00:   sym_val = -AMP_HI;
          2'b01:   sym_val = -AMP_LO;
          2'b11:   sym_val = AMP_LO;
          default: sym_val = AMP_HI;
        endcase
      end
      SRC_CONST: sym_val = AMP_HI;
      SRC_ZERO:  sym_val = '0;
      SRC_ALT:   sym_val = toggle ? -AMP_HI : AMP_HI;
      default:   sym_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_cnt <= '0;
      sam_cnt <= '0;
      lfsr    <= SEED;
      toggle  <= 1'b0;
      x_out   <= '0;
    end else begin
      clk_cnt <= clk_cnt + 2'd1;
      if (sam_clk_en) begin
        sam_cnt <= sam_cnt + 2'd1;
      end
      if (sym_clk_en) begin
        lfsr  <= lfsr_two;
        x_out <= sym_val;
        if (src == SRC_ALT) begin
          toggle <= ~toggle;
        end
      end
`ifdef ZERO_STUFF_EN
      else if (sam_clk_en) begin
        x_out <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sym_src_upsampler.sv
// Randomized self-checking bench for sym_src_upsampler against an edge-count model.
module tb_sym_src_upsampler;

  localparam logic        [14:0] SEED = 15'h0001;
  localparam logic signed [17:0] HI   = 18'sd98304;
  localparam logic signed [17:0] LO   = 18'sd32768;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic        [1:0]  sw = 2'b10;
  logic               sam_clk_en;
  logic               sym_clk_en;
  logic signed [17:0] x_out;
  logic        [1:0]  sam_cnt;
  logic        [21:0] obs;

  int total = 0;
  int bad   = 0;

  sym_src_upsampler #(.SEED(SEED), .AMP_HI(HI), .AMP_LO(LO)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .x_out      (x_out),
    .sam_cnt    (sam_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {sam_clk_en, sym_clk_en, sam_cnt, x_out};

  // Model: n = rising edges since reset release; symbols every 16 edges.
  int                 n;
  logic        [14:0] m_lfsr;
  logic               m_tog;
  logic signed [17:0] m_sym;

  function automatic logic [14:0] shift1(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  function automatic logic signed [17:0] sym_of(input logic [1:0] src, input logic [14:0] s,
                                                input logic tog);
    logic signed [17:0] v;
    v = 18'sd0;
    case (src)
      2'd0: case (s[1:0])
              2'b00: v = -HI;
              2'b01: v = -LO;
              2'b11: v = LO;
              default: v = HI;
            endcase
      2'd1: v = HI;
      2'd2: v = 18'sd0;
      default: v = tog ? -HI : HI;
    endcase
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0; m_lfsr = SEED; m_tog = 1'b0; m_sym = 18'sd0;
    end else begin
      if (n % 16 == 15) begin
        m_sym  = sym_of(sw, m_lfsr, m_tog);
        m_lfsr = shift1(shift1(m_lfsr));
        if (sw == 2'b11) m_tog = ~m_tog;
      end
      n = n + 1;
    end
  end

  function automatic logic [21:0] expected();
    logic               e_sam, e_sym;
    logic        [1:0]  e_cnt;
    logic signed [17:0] e_x;
    e_sam = (n % 4 == 3);
    e_sym = (n % 16 == 15);
    e_cnt = 2'((n / 4) % 4);
`ifdef ZERO_STUFF_EN
    e_x = (n >= 16 && (n % 16) < 4) ? m_sym : 18'sd0;
`else
    e_x = m_sym;
`endif
    return {e_sam, e_sym, e_cnt, e_x};
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_reset();
    int first_sam, first_sym;
    @(negedge clk); reset = 1'b0; sw = 2'b10;
    #1;
    total++;
    if (obs !== 22'd0) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", obs, 22'd0);
    end
    @(negedge clk); reset = 1'b1;
    first_sam = 0; first_sym = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sam_clk_en && first_sam == 0) first_sam = i;
      if (sym_clk_en && first_sym == 0) first_sym = i;
    end
    total++;
    if (first_sam !== 3) begin
      bad++; $display("FAIL first_sam_edge got=%0d exp=3", first_sam);
    end
    total++;
    if (first_sym !== 15) begin
      bad++; $display("FAIL first_sym_edge got=%0d exp=15", first_sym);
    end
  endtask

  task automatic test_source(input logic [1:0] s, input int cycles);
    sw = s;
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      total++;
      if (obs !== expected()) begin
        bad++; $display("FAIL source_sw%0d n=%0d got=%h exp=%h", s, n, obs, expected());
      end
    end
  endtask

  task automatic test_prbs_first_symbols();
    logic signed [17:0] s1, s2;
    sw = 2'b00;
    do_reset();
    repeat (17) @(negedge clk);
    s1 = x_out;
    repeat (16) @(negedge clk);
    s2 = x_out;
    total++;
    if (s1 !== -LO) begin
      bad++; $display("FAIL prbs_sym0 got=%0d exp=%0d", s1, -LO);
    end
    total++;
    if (s2 !== -HI) begin
      bad++; $display("FAIL prbs_sym1 got=%0d exp=%0d", s2, -HI);
    end
  endtask

  task automatic test_switch_mid_symbol();
    int guard;
    sw = 2'b00;
    do_reset();
    guard = 0;
    while (!(n > 16 && n % 16 == 9) && guard < 100) begin
      @(negedge clk); guard++;
    end
    total++;
    if (guard >= 100) begin
      bad++; $display("FAIL switch_wait got=timeout exp=phase9");
    end
    sw = 2'b01;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (obs !== expected()) begin
        bad++; $display("FAIL switch_const n=%0d got=%h exp=%h", n, obs, expected());
      end
      if (n % 16 == 0) begin
        total++;
        if (x_out !== HI) begin
          bad++; $display("FAIL switch_sym got=%0d exp=%0d", x_out, HI);
        end
      end
    end
    sw = 2'b00;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      total++;
      if (obs !== expected()) begin
        bad++; $display("FAIL switch_back n=%0d got=%h exp=%h", n, obs, expected());
      end
    end
  endtask

  task automatic test_reset_mid_symbol();
    int guard, first_sym;
    sw = 2'b11;
    do_reset();
    guard = 0;
    while (!(n > 16 && n % 16 == 9) && guard < 100) begin
      @(negedge clk); guard++;
    end
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 22'd0) begin
      bad++; $display("FAIL midreset_state got=%h exp=%h", obs, 22'd0);
    end
    @(negedge clk); reset = 1'b1;
    first_sym = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sym_clk_en && first_sym == 0) first_sym = i;
    end
    total++;
    if (first_sym !== 15) begin
      bad++; $display("FAIL midreset_first_sym got=%0d exp=15", first_sym);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (obs !== expected()) begin
        bad++; $display("FAIL midreset_run n=%0d got=%h exp=%h", n, obs, expected());
      end
    end
  endtask

  task automatic test_random();
    sw = 2'($urandom);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      total++;
      if (obs !== expected()) begin
        bad++; $display("FAIL random n=%0d sw=%0d got=%h exp=%h", n, sw, obs, expected());
      end
      if ($urandom_range(9, 0) == 0) sw = 2'($urandom);
      if ($urandom_range(199, 0) == 0) begin
        reset = 1'b0;
        #1;
        total++;
        if (obs !== 22'd0) begin
          bad++; $display("FAIL random_reset got=%h exp=%h", obs, 22'd0);
        end
        @(negedge clk); reset = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_source(2'b10, 48);
    test_source(2'b01, 64);
    test_source(2'b11, 80);
    test_source(2'b00, 128);
    test_prbs_first_symbols();
    test_switch_mid_symbol();
    test_reset_mid_symbol();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
